id_ex_hazard_ctrl: RTL

- Consumer-side controller for the ID/EX pipeline register.
- Each cycle it reads the EX-stage copies of Rd, MemRead and RegWrite from ID/EX, the source registers of the instruction in ID, and the resolved taken-branch signal from EX.
- It generates the stall and bubble controls for the front end (PC, IF/ID, ID/EX input mux) and the IF/ID squash control, and keeps saturating stall and flush event counters.
- It runs a small FSM so load-use stalls and branch flushes can span several cycles.

---
 rtl/id_ex_hazard_ctrl.sv | 124 ++++++++++++
 1 files changed

// File: rtl/id_ex_hazard_ctrl.sv
// ID/EX hazard controller: load-use stall, taken-branch flush, saturating event counters.
// Latency: outputs are combinational (Mealy) from state and inputs; no added delay.
// Backpressure: stalls hold PC and IF/ID; flushes bubble ID and squash IF/ID; reset forces both.
module id_ex_hazard_ctrl #(
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int FLUSH_CYCLES      = 2,
    parameter int CNT_W             = 32,
    parameter int ZERO_REG          = 31
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       Rn_ID,
    input  logic [4:0]       Rm_ID,
    input  logic             uses_Rn_ID,
    input  logic             uses_Rm_ID,
    input  logic [4:0]       Rd_EX,
    input  logic             MemRead_EX,
    input  logic             RegWrite_EX,
    input  logic             branch_taken_EX,
    output logic             PCWrite,
    output logic             IFID_Write,
    output logic             bubble_ID,
    output logic             flush_IF_ID,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    localparam logic [1:0] RUN   = 2'd0;
    localparam logic [1:0] STALL = 2'd1;
    localparam logic [1:0] FLUSH = 2'd2;

    localparam logic [3:0] STALL_INIT = 4'(LOAD_STALL_CYCLES - 1);
    localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_CYCLES - 1);

    logic [1:0] state, next_state;
    logic [3:0] cnt, next_cnt;
    logic       hazard;
    logic       stall_inc, flush_inc;

    assign hazard = MemRead_EX && RegWrite_EX && (Rd_EX != 5'(ZERO_REG)) &&
                    ((uses_Rn_ID && (Rn_ID == Rd_EX)) || (uses_Rm_ID && (Rm_ID == Rd_EX)));

    always_comb begin
        next_state  = state;
        next_cnt    = cnt;
        stall_inc   = 1'b0;
        flush_inc   = 1'b0;
        PCWrite     = 1'b1;
        IFID_Write  = 1'b1;
        bubble_ID   = 1'b0;
        flush_IF_ID = 1'b0;
        case (state)
            RUN, STALL: begin
                // A taken branch wins over any hazard, including one already stalling.
                if (branch_taken_EX) begin
                    bubble_ID   = 1'b1;
                    flush_IF_ID = 1'b1;
                    flush_inc   = 1'b1;
                    if (FLUSH_CYCLES > 1) begin
                        next_state = FLUSH;
                        next_cnt   = FLUSH_INIT;
                    end else begin
                        next_state = RUN;
                        next_cnt   = 4'd0;
                    end
                end else if (state == STALL || hazard) begin
                    PCWrite    = 1'b0;
                    IFID_Write = 1'b0;
                    bubble_ID  = 1'b1;
                    stall_inc  = 1'b1;
                    if (state == STALL) begin
                        if (cnt <= 4'd1) begin
                            next_state = RUN;
                            next_cnt   = 4'd0;
                        end else begin
                            next_cnt = cnt - 4'd1;
                        end
                    end else if (LOAD_STALL_CYCLES > 1) begin
                        next_state = STALL;
                        next_cnt   = STALL_INIT;
                    end
                end
            end
            FLUSH: begin
                bubble_ID   = 1'b1;
                flush_IF_ID = 1'b1;
                if (cnt <= 4'd1) begin
                    next_state = RUN;
                    next_cnt   = 4'd0;
                end else begin
                    next_cnt = cnt - 4'd1;
                end
            end
            default: begin
                next_state = RUN;
                next_cnt   = 4'd0;
            end
        endcase
        // Reset overrides the outputs combinationally, without waiting for a clock.
        if (!reset) begin
            PCWrite     = 1'b0;
            IFID_Write  = 1'b0;
            bubble_ID   = 1'b1;
            flush_IF_ID = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= RUN;
            cnt         <= 4'd0;
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            state <= next_state;
            cnt   <= next_cnt;
            if (stall_inc && (stall_count != {CNT_W{1'b1}}))
                stall_count <= stall_count + 1'b1;
            if (flush_inc && (flush_count != {CNT_W{1'b1}}))
                flush_count <= flush_count + 1'b1;
        end
    end

endmodule
